// File: rtl/microwave_pkg.sv
// Shared state encodings, BCD limits and MM:SS arithmetic helpers for the cook timer.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } mmss_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] SEC_WRAP_T = 4'd5;
    localparam mmss_t      MM_SS_MAX  = mmss_t'{4'd9, 4'd9, 4'd5, 4'd9};

    // One-second decrement done digit by digit with borrow, so an entered 00:90 runs 90 s.
    function automatic mmss_t bcd_dec(input mmss_t c);
        mmss_t r;
        r = c;
        if (c.sec_o != 4'd0) begin
            r.sec_o = c.sec_o - 4'd1;
        end else if (c.sec_t != 4'd0) begin
            r.sec_t = c.sec_t - 4'd1;
            r.sec_o = BCD_MAX;
        end else if ((c.min_t != 4'd0) || (c.min_o != 4'd0)) begin
            r.sec_t = SEC_WRAP_T;
            r.sec_o = BCD_MAX;
            if (c.min_o != 4'd0) begin
                r.min_o = c.min_o - 4'd1;
            end else begin
                r.min_o = BCD_MAX;
                r.min_t = c.min_t - 4'd1;
            end
        end
        return r;
    endfunction

    // Adds 30 s; seconds (which may exceed 59 from keypad entry) fold into minutes, saturating at 99:59.
    function automatic mmss_t bcd_add30(input mmss_t c);
        logic [7:0] s;
        logic [7:0] m;
        mmss_t      r;
        s = 8'(c.sec_t) * 8'd10 + 8'(c.sec_o) + 8'd30;
        m = 8'(c.min_t) * 8'd10 + 8'(c.min_o);
        if (s >= 8'd120) begin
            s = s - 8'd120;
            m = m + 8'd2;
        end else if (s >= 8'd60) begin
            s = s - 8'd60;
            m = m + 8'd1;
        end
        if (m > 8'd99) begin
            r = MM_SS_MAX;
        end else begin
            r = mmss_t'{4'(m / 8'd10), 4'(m % 8'd10), 4'(s / 8'd10), 4'(s % 8'd10)};
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_timer_if.sv
// Keypad, control and display bundle between the timer and its surroundings.
// COOK_TIMER_ADD30_EN adds the add30 strobe.
interface cook_timer_if;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       mag_on;
`ifdef COOK_TIMER_ADD30_EN
    logic       add30;
`endif
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       timer_done;
    logic       running;

`ifdef COOK_TIMER_ADD30_EN
    modport master (output clearn, digit_valid, digit, mag_on, add30,
                    input  min_t, min_o, sec_t, sec_o, timer_done, running);
    modport slave  (input  clearn, digit_valid, digit, mag_on, add30,
                    output min_t, min_o, sec_t, sec_o, timer_done, running);
`else
    modport master (output clearn, digit_valid, digit, mag_on,
                    input  min_t, min_o, sec_t, sec_o, timer_done, running);
    modport slave  (input  clearn, digit_valid, digit, mag_on,
                    output min_t, min_o, sec_t, sec_o, timer_done, running);
`endif
endinterface

// File: rtl/cook_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, holds otherwise, tick on the last count.
module cook_tick_gen #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            W    = $clog2(CLK_HZ);
    localparam logic [W-1:0]  LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // NOTE: state registers use non-blocking assignments and clear on the async reset edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Cook-time MM:SS countdown: keypad entry, 1 s countdown while mag_on, timer_done at 00:00.
// COOK_TIMER_ADD30_EN enables the +30 s strobe.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    cook_timer_if.slave bus
);

    state_e state_q;
    mmss_t  cnt_q;
    logic   done_q;
    logic   run_q;

    logic   tick;
    logic   tick_en;
    logic   clr;
    logic   entry_ok;
    logic   add_hit;
    mmss_t  dec_cnt;
    mmss_t  tick_cnt;
    mmss_t  entry_base;
    mmss_t  entry_cnt;
    mmss_t  add_cnt;

    assign clr     = !bus.clearn;
    assign tick_en = (state_q == ST_RUN);

    cook_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .en     (tick_en),
        .tick   (tick)
    );

    // NOTE: every always_comb output gets a value on every path, so no latches appear.
    always_comb begin
        dec_cnt    = bcd_dec(cnt_q);
        tick_cnt   = tick ? dec_cnt : cnt_q;
        entry_ok   = bus.digit_valid && (bus.digit <= BCD_MAX)
                     && (state_q inside {ST_IDLE, ST_SET, ST_DONE});
        entry_base = (state_q == ST_DONE) ? '0 : cnt_q;
        entry_cnt  = mmss_t'{entry_base.min_o, entry_base.sec_t, entry_base.sec_o, bus.digit};
`ifdef COOK_TIMER_ADD30_EN
        add_hit    = bus.add30;
        add_cnt    = bcd_add30(tick_cnt);
`else
        add_hit    = 1'b0;
        add_cnt    = tick_cnt;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SET, ST_DONE: begin
                    if (entry_ok) begin
                        cnt_q   <= entry_cnt;
                        state_q <= (entry_cnt == '0) ? ST_IDLE : ST_SET;
                        done_q  <= 1'b0;
                    end else if (add_hit) begin
                        cnt_q  <= add_cnt;
                        done_q <= 1'b0;
                        if ((state_q == ST_SET) && bus.mag_on) begin
                            state_q <= ST_RUN;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SET;
                        end
                    end else if ((state_q == ST_SET) && bus.mag_on) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= add_hit ? add_cnt : tick_cnt;
                    // Reaching zero wins over a simultaneous mag_on drop.
                    if (tick && (dec_cnt == '0) && !add_hit) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        run_q   <= 1'b0;
                    end else if (!bus.mag_on) begin
                        state_q <= ST_PAUSE;
                        run_q   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (add_hit) begin
                        cnt_q <= add_cnt;
                    end
                    if (bus.mag_on) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_t      = cnt_q.min_t;
    assign bus.min_o      = cnt_q.min_o;
    assign bus.sec_t      = cnt_q.sec_t;
    assign bus.sec_o      = cnt_q.sec_o;
    assign bus.timer_done = done_q;
    assign bus.running    = run_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer at CLK_HZ=4; the add30 steps build with COOK_TIMER_ADD30_EN.
module tb_cook_timer;
    import microwave_pkg::*;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    cook_timer_if bus ();

    cook_timer #(.CLK_HZ(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] disp();
        return {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        step(1);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic clear();
        bus.clearn = 1'b0;
        step(1);
        bus.clearn = 1'b1;
    endtask

`ifdef COOK_TIMER_ADD30_EN
    task automatic add30();
        bus.add30 = 1'b1;
        step(1);
        bus.add30 = 1'b0;
    endtask
`endif

    initial begin
        vectors         = 0;
        miscompares     = 0;
        resetn          = 1'b0;
        bus.clearn      = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.mag_on      = 1'b0;
`ifdef COOK_TIMER_ADD30_EN
        bus.add30       = 1'b0;
`endif
        step(2);
        check("reset_disp", disp(), 16'h0000);
        check("reset_done", 16'(bus.timer_done), 16'h0);
        check("reset_run", 16'(bus.running), 16'h0);
        check("reset_state", 16'(dut.state_q), 16'(ST_IDLE));
        resetn = 1'b1;
        step(1);

        // Entry 1,3,0 -> 01:30, invalid digit ignored
        key(4'd1); key(4'd3); key(4'd0);
        check("entry_disp", disp(), 16'h0130);
        check("entry_state", 16'(dut.state_q), 16'(ST_SET));
        check("entry_done", 16'(bus.timer_done), 16'h0);
        key(4'd12);
        check("bad_digit", disp(), 16'h0130);
        clear();
        check("clear_disp", disp(), 16'h0000);
        check("clear_state", 16'(dut.state_q), 16'(ST_IDLE));

        // 00:02 countdown to DONE
        key(4'd0); key(4'd0); key(4'd0);
        check("zero_entry_idle", 16'(dut.state_q), 16'(ST_IDLE));
        key(4'd2);
        check("two_disp", disp(), 16'h0002);
        bus.mag_on = 1'b1;
        step(1);
        check("run_entry", 16'(bus.running), 16'h1);
        step(3);
        check("pre_tick", disp(), 16'h0002);
        step(1);
        check("first_tick", disp(), 16'h0001);
        step(3);
        check("pre_done", 16'(bus.timer_done), 16'h0);
        step(1);
        check("done_disp", disp(), 16'h0000);
        check("done_flag", 16'(bus.timer_done), 16'h1);
        check("done_run", 16'(bus.running), 16'h0);
        bus.mag_on = 1'b0;
        step(3);
        check("done_hold", 16'(dut.state_q), 16'(ST_DONE));
        check("done_flag_hold", 16'(bus.timer_done), 16'h1);

        // Entry from DONE restarts at zero; 01:00 -> 00:59
        key(4'd1);
        check("done_entry", disp(), 16'h0001);
        check("done_entry_flag", 16'(bus.timer_done), 16'h0);
        key(4'd0); key(4'd0);
        check("min_entry", disp(), 16'h0100);
        bus.mag_on = 1'b1;
        step(5);
        check("min_borrow", disp(), 16'h0059);
        bus.mag_on = 1'b0;
        step(1);
        check("pause_state", 16'(dut.state_q), 16'(ST_PAUSE));
        clear();

        // 00:90 -> 00:89, then pause keeps the partial second
        key(4'd9); key(4'd0);
        bus.mag_on = 1'b1;
        step(5);
        check("sec90", disp(), 16'h0089);
        step(2);
        bus.mag_on = 1'b0;
        step(1);
        check("pause_run", 16'(bus.running), 16'h0);
        step(9);
        check("pause_frozen", disp(), 16'h0089);
        key(4'd3);
        check("pause_entry_ign", disp(), 16'h0089);
        bus.mag_on = 1'b1;
        step(1);
        check("resume_run", 16'(bus.running), 16'h1);
        check("resume_disp", disp(), 16'h0089);
        step(1);
        check("resume_tick", disp(), 16'h0088);

        // clearn while running
        clear();
        key(4'd7);
        step(2);
        check("run_07", disp(), 16'h0007);
        bus.clearn = 1'b0;
        step(1);
        bus.clearn = 1'b1;
        check("clr_run_disp", disp(), 16'h0000);
        check("clr_run_state", 16'(dut.state_q), 16'(ST_IDLE));
        check("clr_run_running", 16'(bus.running), 16'h0);

        // async reset mid-RUN
        key(4'd5);
        step(2);
        check("pre_reset_run", 16'(bus.running), 16'h1);
        resetn = 1'b0;
        #1;
        check("async_disp", disp(), 16'h0000);
        check("async_run", 16'(bus.running), 16'h0);
        bus.mag_on = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);

`ifdef COOK_TIMER_ADD30_EN
        key(4'd4); key(4'd5);
        add30();
        check("add30_45", disp(), 16'h0115);
        check("add30_set", 16'(dut.state_q), 16'(ST_SET));
        clear();
        key(4'd9); key(4'd9); key(4'd5); key(4'd0);
        add30();
        check("add30_sat", disp(), 16'h9959);
        clear();
        key(4'd1);
        bus.mag_on = 1'b1;
        step(5);
        bus.mag_on = 1'b0;
        check("add30_pre_done", 16'(bus.timer_done), 16'h1);
        add30();
        check("add30_done_disp", disp(), 16'h0030);
        check("add30_done_flag", 16'(bus.timer_done), 16'h0);
        check("add30_done_state", 16'(dut.state_q), 16'(ST_SET));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
